// File: rtl/fifo0_pkg.sv
// fifo0_pkg: shared definitions for the fifo0 single-clock FIFO controller.
//   occ_state_e    occupancy state (empty / partially filled / full)
//   ptr_width()    pointer width for a given RAM address width (wrap bit + address)
//   count_width()  occupancy counter width (must represent 0..DEPTH)
//   def_afull_th() default almost_full threshold (DEPTH-2)
//   DEF_AEMPTY_TH  default almost_empty threshold
package fifo0_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } occ_state_e;

  localparam int DEF_AEMPTY_TH = 2;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int def_afull_th(input int addr_width);
    return (1 << addr_width) - 2;
  endfunction

endpackage

// File: rtl/fifo0_ptr.sv
// fifo0_ptr: wrap-bit pointer for the fifo0 circular buffer.
//   wr_clk    clock
//   asyn_rst  asynchronous active-high reset, clears the pointer to 0
//   inc       advance the pointer by one slot
//   ptr       ADDR_WIDTH+1 bits; low bits address the RAM, MSB toggles on each wrap
// Because the pointer is exactly one bit wider than the address, a plain
// binary increment wraps DEPTH-1 -> 0 and toggles the wrap bit at the same time.
module fifo0_ptr
  import fifo0_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                                wr_clk,
  input  logic                                asyn_rst,
  input  logic                                inc,
  output logic [ptr_width(ADDR_WIDTH)-1:0]    ptr
);

  localparam int PW = ptr_width(ADDR_WIDTH);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) ptr <= '0;
    else if (inc) ptr <= ptr + PW'(1);
  end

endmodule

// File: rtl/fifo0_sync_ctrl.sv
// fifo0_sync_ctrl: single-clock FIFO controller sequencing one external
// ipm_distributed_sdpram as a circular buffer.
//   wr_clk, asyn_rst        sole clock; asynchronous active-high reset
//   push, push_data         write request and payload
//   pop                     read request
//   pop_data, pop_valid     read payload, valid one cycle after an accepted pop
//   full, empty             occupancy state decode
//   almost_full/empty       count >= AFULL_TH / count <= AEMPTY_TH (registered)
//   count                   occupancy 0..DEPTH
//   ram_wr_en/addr/data     RAM write port
//   ram_rd_addr, ram_rd_data RAM read port (head of queue always addressed)
// OUT_REG must match the RAM's OUT_REG: 0 = combinational RAM read, registered
// here; 1 = RAM registers its output, passed straight through.
// Optional macro FIFO0_CTRL_ERR_STATUS_EN adds err_clr, overflow, underflow.
module fifo0_sync_ctrl
  import fifo0_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int OUT_REG    = 0,
  parameter int AFULL_TH   = def_afull_th(ADDR_WIDTH),
  parameter int AEMPTY_TH  = DEF_AEMPTY_TH
) (
  input  logic                        wr_clk,
  input  logic                        asyn_rst,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       push_data,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       pop_data,
  output logic                        pop_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [ADDR_WIDTH:0]         count,
  output logic                        ram_wr_en,
  output logic [ADDR_WIDTH-1:0]       ram_wr_addr,
  output logic [DATA_WIDTH-1:0]       ram_wr_data,
  output logic [ADDR_WIDTH-1:0]       ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]       ram_rd_data
`ifdef FIFO0_CTRL_ERR_STATUS_EN
  ,
  input  logic                        err_clr,
  output logic                        overflow,
  output logic                        underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  occ_state_e            state, state_nxt;
  logic [CW-1:0]         count_nxt;
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic                  rd_acc, wr_acc;

  // A push at full only succeeds when a pop frees the slot in the same cycle;
  // a pop at empty is never served, even by a concurrent push (no bypass).
  assign rd_acc = pop & ~empty;
  assign wr_acc = push & (~full | rd_acc);

  fifo0_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .wr_clk   (wr_clk),
    .asyn_rst (asyn_rst),
    .inc      (wr_acc),
    .ptr      (wr_ptr)
  );

  fifo0_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .wr_clk   (wr_clk),
    .asyn_rst (asyn_rst),
    .inc      (rd_acc),
    .ptr      (rd_ptr)
  );

  // NOTE: RAM contents are deliberately not reset; the pointers are, which
  // makes any stale words unreachable until they are rewritten.
  assign ram_wr_en   = wr_acc;
  assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_data = push_data;
  assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (wr_acc && !rd_acc)      count_nxt = count + CW'(1);
    else if (rd_acc && !wr_acc) count_nxt = count - CW'(1);
    case (state)
      ST_EMPTY:   if (wr_acc) state_nxt = ST_PARTIAL;
      ST_PARTIAL: begin
        if (rd_acc && !wr_acc && count == CW'(1))
          state_nxt = ST_EMPTY;
        else if (wr_acc && !rd_acc && count == CW'(DEPTH - 1))
          state_nxt = ST_FULL;
      end
      ST_FULL:    if (rd_acc && !wr_acc) state_nxt = ST_PARTIAL;
      default:    state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      state        <= ST_EMPTY;
      count        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      pop_valid    <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      almost_full  <= (count_nxt >= AFULL_C);
      almost_empty <= (count_nxt <= AEMPTY_C);
      pop_valid    <= rd_acc;
    end
  end

  assign empty = (state == ST_EMPTY);
  assign full  = (state == ST_FULL);

  // Both alignment paths present the head word one cycle after the pop: the
  // RAM output register (OUT_REG=1) or the local register (OUT_REG=0) samples
  // the old head address on the same edge that advances rd_ptr. At full with
  // push+pop on one slot, that read sees the word before the write lands.
  generate
    if (OUT_REG != 0) begin : g_ram_reg
      assign pop_data = ram_rd_data;
    end else begin : g_ctrl_reg
      logic [DATA_WIDTH-1:0] pop_data_q;
      always_ff @(posedge wr_clk or posedge asyn_rst) begin
        if (asyn_rst)    pop_data_q <= '0;
        else if (rd_acc) pop_data_q <= ram_rd_data;
      end
      assign pop_data = pop_data_q;
    end
  endgenerate

`ifdef FIFO0_CTRL_ERR_STATUS_EN
  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && !wr_acc) overflow <= 1'b1;
      else if (err_clr)    overflow <= 1'b0;
      if (pop && empty)    underflow <= 1'b1;
      else if (err_clr)    underflow <= 1'b0;
    end
  end
`endif

  // Pointer distance must always equal the tracked occupancy.
  a_count_matches_ptrs : assert property (
    @(posedge wr_clk) disable iff (asyn_rst) (wr_ptr - rd_ptr) == count);

endmodule

// File: tb/tb_fifo0_sync_ctrl.sv
// tb_fifo0_sync_ctrl: runs identical stimulus into two controllers (OUT_REG=0
// and OUT_REG=1), each with its own behavioural RAM, and compares both against
// a queue-based FIFO reference model.
module tb_fifo0_sync_ctrl;

  localparam int AW        = 4;
  localparam int DW        = 16;
  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = 14;
  localparam int AEMPTY_TH = 2;

  logic          wr_clk = 1'b0;
  logic          asyn_rst;
  logic          push, pop, err_clr;
  logic [DW-1:0] push_data;

  logic [DW-1:0] pop_data    [2];
  logic          pop_valid   [2];
  logic          full        [2];
  logic          empty       [2];
  logic          almost_full [2];
  logic          almost_empty[2];
  logic [AW:0]   count       [2];
  logic          ram_wr_en   [2];
  logic [AW-1:0] ram_wr_addr [2];
  logic [DW-1:0] ram_wr_data [2];
  logic [AW-1:0] ram_rd_addr [2];
  logic [DW-1:0] ram_rd_data [2];
  logic          overflow    [2];
  logic          underflow   [2];

  always #5 wr_clk = ~wr_clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q;

    fifo0_sync_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .OUT_REG    (k)
    ) u_dut (
      .wr_clk       (wr_clk),
      .asyn_rst     (asyn_rst),
      .push         (push),
      .push_data    (push_data),
      .pop          (pop),
      .pop_data     (pop_data[k]),
      .pop_valid    (pop_valid[k]),
      .full         (full[k]),
      .empty        (empty[k]),
      .almost_full  (almost_full[k]),
      .almost_empty (almost_empty[k]),
      .count        (count[k]),
      .ram_wr_en    (ram_wr_en[k]),
      .ram_wr_addr  (ram_wr_addr[k]),
      .ram_wr_data  (ram_wr_data[k]),
      .ram_rd_addr  (ram_rd_addr[k]),
      .ram_rd_data  (ram_rd_data[k])
`ifdef FIFO0_CTRL_ERR_STATUS_EN
      ,
      .err_clr      (err_clr),
      .overflow     (overflow[k]),
      .underflow    (underflow[k])
`endif
    );

`ifndef FIFO0_CTRL_ERR_STATUS_EN
    assign overflow[k]  = 1'b0;
    assign underflow[k] = 1'b0;
`endif

    // Behavioural RAM: synchronous write, combinational read, optional output register.
    always @(posedge wr_clk) begin
      if (ram_wr_en[k]) mem[ram_wr_addr[k]] <= ram_wr_data[k];
    end
    always @(posedge wr_clk or posedge asyn_rst) begin
      if (asyn_rst) q <= '0;
      else          q <= mem[ram_rd_addr[k]];
    end
    assign ram_rd_data[k] = (k == 1) ? q : mem[ram_rd_addr[k]];
  end

  // Reference model
  logic [DW-1:0] model[$];
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic          exp_ovf, exp_udf;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    int n = model.size();
    for (int k = 0; k < 2; k++) begin
      string s = $sformatf("or%0d", k);
      check({s, ".count"},        64'(count[k]),     64'(n));
      check({s, ".empty"},        64'(empty[k]),     64'(n == 0));
      check({s, ".full"},         64'(full[k]),      64'(n == DEPTH));
      check({s, ".almost_full"},  64'(almost_full[k]),  64'(n >= AFULL_TH));
      check({s, ".almost_empty"}, 64'(almost_empty[k]), 64'(n <= AEMPTY_TH));
      check({s, ".pop_valid"},    64'(pop_valid[k]), 64'(exp_valid));
      if (exp_valid) check({s, ".pop_data"}, 64'(pop_data[k]), 64'(exp_data));
`ifdef FIFO0_CTRL_ERR_STATUS_EN
      check({s, ".overflow"},  64'(overflow[k]),  64'(exp_ovf));
      check({s, ".underflow"}, 64'(underflow[k]), 64'(exp_udf));
`endif
    end
  endtask

  task automatic clear_model();
    model.delete();
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_ovf   = 1'b0;
    exp_udf   = 1'b0;
  endtask

  task automatic check_reset_data();
    for (int k = 0; k < 2; k++)
      check($sformatf("or%0d.rst_pop_data", k), 64'(pop_data[k]), 64'(0));
  endtask

  // One clock cycle: drive at negedge, check combinational RAM enable,
  // advance the model, then check registered outputs just after posedge.
  task automatic step(input logic p, input logic [DW-1:0] d, input logic r, input logic c);
    int  n;
    bit  rd_ok, wr_ok;
    @(negedge wr_clk);
    push = p; push_data = d; pop = r; err_clr = c;
    n     = model.size();
    rd_ok = r && (n > 0);
    wr_ok = p && ((n < DEPTH) || rd_ok);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("or%0d.ram_wr_en", k), 64'(ram_wr_en[k]), 64'(wr_ok));
      if (wr_ok) check($sformatf("or%0d.ram_wr_data", k), 64'(ram_wr_data[k]), 64'(d));
    end
    exp_ovf = (p && !wr_ok) ? 1'b1 : (c ? 1'b0 : exp_ovf);
    exp_udf = (r && n == 0) ? 1'b1 : (c ? 1'b0 : exp_udf);
    exp_valid = rd_ok;
    if (rd_ok) exp_data = model.pop_front();
    if (wr_ok) model.push_back(d);
    @(posedge wr_clk);
    #1;
    check_state();
  endtask

  task automatic mid_reset();
    @(negedge wr_clk);
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    #2 asyn_rst = 1'b1;
    clear_model();
    #1;
    check_state();
    check_reset_data();
    #1 asyn_rst = 1'b0;
  endtask

  initial begin
    asyn_rst = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_data = '0;
    clear_model();
    repeat (2) @(negedge wr_clk);
    #1;
    check_state();
    check_reset_data();
    asyn_rst = 1'b0;

    // Idle after reset
    repeat (4) step(1'b0, '0, 1'b0, 1'b0);

    // Fill to full, then one refused push
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    step(1'b1, 16'h0011, 1'b0, 1'b0);

    // Drain in order, then one extra pop on empty
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Full with simultaneous push/pop across the pointer wrap
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 16'hAAAA, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Push and pop together on empty: pop refused, word kept
    step(1'b1, 16'h5555, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Reset at count 9 between edges, then reuse
    for (int i = 0; i < 9; i++) step(1'b1, DW'(16'h0200 + i), 1'b0, 1'b0);
    mid_reset();
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

`ifdef FIFO0_CTRL_ERR_STATUS_EN
    // Overflow on a refused push, cleared by err_clr; underflow with set-wins clear
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(16'h0300 + i), 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
`endif

    // Randomised traffic in phases biased towards filling, draining and balance
    for (int i = 0; i < 600; i++) begin
      int pw, rw;
      case ((i / 100) % 3)
        0:       begin pw = 80; rw = 30; end
        1:       begin pw = 30; rw = 80; end
        default: begin pw = 60; rw = 60; end
      endcase
      step($urandom_range(0, 99) < pw, DW'($urandom), $urandom_range(0, 99) < rw,
           $urandom_range(0, 15) == 0);
    end
    for (int i = 0; i <= DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
